// File: rtl/hps_cmd_pkg.sv
// rtl/hps_cmd_pkg.sv - shared widths, command struct and opcodes for the HPS command bridge
//
// Purpose: default field widths, the packed command record and the opcode
// values agreed with the accelerator core. No ports (package).

package hps_cmd_pkg;

    localparam int DEF_INSTR_W    = 3;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 17;
    localparam int DEF_NUM_MEMS   = 2;
    localparam int DEF_FIFO_DEPTH = 4;

    // Memory-select width: max(1, clog2(num_mems)).
    function automatic int sel_width(input int num_mems);
        return (num_mems > 2) ? $clog2(num_mems) : 1;
    endfunction

    localparam int DEF_SEL_W = sel_width(DEF_NUM_MEMS);

    typedef struct packed {
        logic [DEF_INSTR_W-1:0] instr;
        logic [DEF_DATA_W-1:0]  data;
        logic [DEF_ADDR_W-1:0]  addr;
        logic [DEF_SEL_W-1:0]   sel;
    } cmd_t;

    localparam logic [DEF_INSTR_W-1:0] OP_NOP       = 3'd0;
    localparam logic [DEF_INSTR_W-1:0] OP_WRITE_MEM = 3'd1;
    localparam logic [DEF_INSTR_W-1:0] OP_READ_MEM  = 3'd2;
    localparam logic [DEF_INSTR_W-1:0] OP_RUN       = 3'd3;
    localparam logic [DEF_INSTR_W-1:0] OP_CLEAR     = 3'd4;

endpackage

// File: rtl/hps_cmd_fifo.sv
// rtl/hps_cmd_fifo.sv - generic first-word-fall-through FIFO with occupancy flags
//
// Purpose: DEPTH-entry FWFT queue. The head word and m_tvalid come only from
// registered state (memory + pointers), so there is no input-to-output bypass.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   s_tvalid/s_tready/s_tdata   write side; s_tready also high when full but popping
//   m_tvalid/m_tready/m_tdata   read side; m_tdata is zero while empty
//   count, full, empty   occupancy

module hps_cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    // Pointers carry one extra MSB so full (diff == DEPTH) and empty (diff == 0) differ.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             push;
    logic             pop;

    // Flags depend only on registered state and m_tready, never on s_tvalid.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        full     = (count == DEPTH_CNT);
        empty    = (count == '0);
        m_tvalid = ~empty;
        pop      = m_tvalid & m_tready;
        s_tready = ~full | pop;
        m_tdata  = m_tvalid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    end

    always_comb begin
        push     = s_tvalid & s_tready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = s_tdata;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: m_tdata is masked while empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/hps_cmd_bridge.sv
// rtl/hps_cmd_bridge.sv - HPS PIO command set to buffered valid/ready command stream
//
// Purpose: a rising edge on pio_enable captures {instruction, data, mem_addr,
// sel_mem} into a FWFT FIFO drained over cmd_valid/cmd_ready. Status back to HPS.
// Ports:
//   clk_clk, reset_reset_n          clock, synchronous active-low reset
//   pio_enable, pio_instruction, pio_data, pio_mem_addr, pio_sel_mem   HPS command PIOs
//   ovf_clear                       pulse clearing sticky overflow (and stats)
//   cmd_valid/cmd_ready, cmd_instr/cmd_data/cmd_addr/cmd_sel   command stream head
//   status_count/full/empty/overflow  FIFO status for the HPS
// Build option HPS_CMD_BRIDGE_STATS_EN adds stat_accepted / stat_dropped
// (16-bit saturating counters, cleared by reset or ovf_clear).

module hps_cmd_bridge
    import hps_cmd_pkg::*;
#(
    parameter int INSTR_W    = DEF_INSTR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_MEMS   = DEF_NUM_MEMS,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int SEL_W      = sel_width(NUM_MEMS)
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          pio_enable,
    input  logic [INSTR_W-1:0]            pio_instruction,
    input  logic [DATA_W-1:0]             pio_data,
    input  logic [ADDR_W-1:0]             pio_mem_addr,
    input  logic [SEL_W-1:0]              pio_sel_mem,
    input  logic                          ovf_clear,
    output logic                          cmd_valid,
    input  logic                          cmd_ready,
    output logic [INSTR_W-1:0]            cmd_instr,
    output logic [DATA_W-1:0]             cmd_data,
    output logic [ADDR_W-1:0]             cmd_addr,
    output logic [SEL_W-1:0]              cmd_sel,
    output logic [$clog2(FIFO_DEPTH):0]   status_count,
    output logic                          status_full,
    output logic                          status_empty,
`ifdef HPS_CMD_BRIDGE_STATS_EN
    output logic [15:0]                   stat_accepted,
    output logic [15:0]                   stat_dropped,
`endif
    output logic                          status_overflow
);

    localparam int CMD_W = INSTR_W + DATA_W + ADDR_W + SEL_W;

    logic             en_q, en_d;
    logic             ovf_q, ovf_d;
    logic             submit;
    logic             accept;
    logic             drop;
    logic             fifo_s_tready;
    logic [CMD_W-1:0] fifo_head;

    // en_q resets to 1 so an enable already high when reset lifts is not a submit.
    assign submit = pio_enable & ~en_q;

    always_comb begin
        en_d   = pio_enable;
        accept = submit & fifo_s_tready;
        // fifo_s_tready already includes "full but popping this cycle".
        drop   = submit & ~fifo_s_tready;
        ovf_d  = ovf_q;
        if (ovf_clear) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            en_q  <= 1'b1;
            ovf_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            ovf_q <= ovf_d;
        end
    end

    hps_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_clk),
        .resetn   (reset_reset_n),
        .s_tvalid (submit),
        .s_tready (fifo_s_tready),
        .s_tdata  ({pio_instruction, pio_data, pio_mem_addr, pio_sel_mem}),
        .m_tvalid (cmd_valid),
        .m_tready (cmd_ready),
        .m_tdata  (fifo_head),
        .count    (status_count),
        .full     (status_full),
        .empty    (status_empty)
    );

    assign {cmd_instr, cmd_data, cmd_addr, cmd_sel} = fifo_head;
    assign status_overflow = ovf_q;

`ifdef HPS_CMD_BRIDGE_STATS_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] drp_q, drp_d;

    // Saturating counters; a clear in the same cycle as an increment wins.
    always_comb begin
        acc_d = acc_q;
        drp_d = drp_q;
        if (accept && (acc_q != 16'hFFFF)) begin
            acc_d = acc_q + 16'd1;
        end
        if (drop && (drp_q != 16'hFFFF)) begin
            drp_d = drp_q + 16'd1;
        end
        if (ovf_clear) begin
            acc_d = '0;
            drp_d = '0;
        end
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            acc_q <= '0;
            drp_q <= '0;
        end else begin
            acc_q <= acc_d;
            drp_q <= drp_d;
        end
    end

    assign stat_accepted = acc_q;
    assign stat_dropped  = drp_q;
`endif

endmodule

// File: tb/tb_hps_cmd_bridge.sv
// tb/tb_hps_cmd_bridge.sv - directed table-driven bench for hps_cmd_bridge

module tb_hps_cmd_bridge;
    import hps_cmd_pkg::*;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        pio_enable;
    logic [2:0]  pio_instruction;
    logic [7:0]  pio_data;
    logic [16:0] pio_mem_addr;
    logic [0:0]  pio_sel_mem;
    logic        ovf_clear;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_instr;
    logic [7:0]  cmd_data;
    logic [16:0] cmd_addr;
    logic [0:0]  cmd_sel;
    logic [2:0]  status_count;
    logic        status_full;
    logic        status_empty;
    logic        status_overflow;
`ifdef HPS_CMD_BRIDGE_STATS_EN
    logic [15:0] stat_accepted;
    logic [15:0] stat_dropped;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk_clk = ~clk_clk;

    hps_cmd_bridge dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .pio_enable      (pio_enable),
        .pio_instruction (pio_instruction),
        .pio_data        (pio_data),
        .pio_mem_addr    (pio_mem_addr),
        .pio_sel_mem     (pio_sel_mem),
        .ovf_clear       (ovf_clear),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_instr       (cmd_instr),
        .cmd_data        (cmd_data),
        .cmd_addr        (cmd_addr),
        .cmd_sel         (cmd_sel),
        .status_count    (status_count),
        .status_full     (status_full),
        .status_empty    (status_empty),
`ifdef HPS_CMD_BRIDGE_STATS_EN
        .stat_accepted   (stat_accepted),
        .stat_dropped    (stat_dropped),
`endif
        .status_overflow (status_overflow)
    );

    typedef struct packed {
        logic       en;
        cmd_t       cmd;
        logic       rdy;
        logic       clr;
        logic       ev;
        cmd_t       ecmd;
        logic [2:0] ecnt;
        logic       eovf;
    } vec_t;

    vec_t vecs[$];

    function automatic cmd_t mkc(input logic [2:0] i, input logic [7:0] d,
                                 input logic [16:0] a, input logic s);
        cmd_t c;
        c.instr = i;
        c.data  = d;
        c.addr  = a;
        c.sel   = s;
        return c;
    endfunction

    function automatic vec_t mk(input logic en, input cmd_t cmd, input logic rdy,
                                input logic clr, input logic ev, input cmd_t ecmd,
                                input logic [2:0] ecnt, input logic eovf);
        vec_t v;
        v.en = en; v.cmd = cmd; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ecmd = ecmd; v.ecnt = ecnt; v.eovf = eovf;
        return v;
    endfunction

    function automatic logic [35:0] obs();
        return {cmd_valid, cmd_instr, cmd_data, cmd_addr, cmd_sel,
                status_count, status_full, status_empty, status_overflow};
    endfunction

    // Expected observation: payload is zero whenever nothing is valid.
    function automatic logic [35:0] expv(input logic v, input cmd_t c,
                                         input logic [2:0] n, input logic o);
        cmd_t cc;
        cc = v ? c : '0;
        return {v, cc, n, (n == 3'd4), (n == 3'd0), o};
    endfunction

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input cmd_t c);
        pio_instruction = c.instr;
        pio_data        = c.data;
        pio_mem_addr    = c.addr;
        pio_sel_mem     = c.sel;
    endtask

    task automatic submit(input cmd_t c);
        drive_cmd(c);
        pio_enable = 1'b1;
        tick();
        pio_enable = 1'b0;
        tick();
    endtask

    cmd_t ca, cb, cc_, cd, ce, cf, cg, ch, ci, cj, ck, cz;

    initial begin
        ca  = mkc(3'b101, 8'hA5, 17'h1_2345, 1'b1);
        cb  = mkc(3'd1, 8'h11, 17'h0_0001, 1'b0);
        cc_ = mkc(3'd2, 8'h22, 17'h1_FFFF, 1'b1);
        cd  = mkc(3'd3, 8'h33, 17'h0_AAAA, 1'b0);
        ce  = mkc(3'd4, 8'h44, 17'h1_5555, 1'b1);
        cf  = mkc(3'd6, 8'h66, 17'h0_0F0F, 1'b0);
        cg  = mkc(3'd7, 8'h77, 17'h1_0000, 1'b1);
        ch  = mkc(3'd0, 8'hFF, 17'h0_1234, 1'b1);
        ci  = mkc(3'd5, 8'h5A, 17'h1_ABCD, 1'b0);
        cj  = mkc(3'd2, 8'hC3, 17'h0_7777, 1'b1);
        ck  = mkc(3'd3, 8'h3C, 17'h1_8888, 1'b0);
        cz  = '0;

        //           en  cmd  rdy clr  ev ecmd cnt  ovf
        vecs.push_back(mk(1, cb,  0, 0, 1, cb,  3'd1, 0)); // fill
        vecs.push_back(mk(0, cf,  0, 0, 1, cb,  3'd1, 0)); // junk payload, no edge
        vecs.push_back(mk(1, cc_, 0, 0, 1, cb,  3'd2, 0));
        vecs.push_back(mk(0, cz,  0, 0, 1, cb,  3'd2, 0));
        vecs.push_back(mk(1, cd,  0, 0, 1, cb,  3'd3, 0));
        vecs.push_back(mk(0, cz,  0, 0, 1, cb,  3'd3, 0));
        vecs.push_back(mk(1, ce,  0, 0, 1, cb,  3'd4, 0)); // full
        vecs.push_back(mk(0, cz,  0, 0, 1, cb,  3'd4, 0));
        vecs.push_back(mk(1, cf,  0, 0, 1, cb,  3'd4, 1)); // dropped
        vecs.push_back(mk(0, cz,  0, 0, 1, cb,  3'd4, 1)); // sticky
        vecs.push_back(mk(0, cz,  0, 1, 1, cb,  3'd4, 0)); // clear
        vecs.push_back(mk(1, cg,  0, 1, 1, cb,  3'd4, 1)); // drop + clear: set wins
        vecs.push_back(mk(0, cz,  0, 0, 1, cb,  3'd4, 1));
        vecs.push_back(mk(0, cz,  0, 1, 1, cb,  3'd4, 0));
        vecs.push_back(mk(1, ch,  1, 0, 1, cc_, 3'd4, 0)); // full: pop + push, no drop
        vecs.push_back(mk(0, cz,  1, 0, 1, cd,  3'd3, 0));
        vecs.push_back(mk(0, cz,  1, 0, 1, ce,  3'd2, 0));
        vecs.push_back(mk(0, cz,  1, 0, 1, ch,  3'd1, 0)); // H drained after C,D,E
        vecs.push_back(mk(0, cz,  1, 0, 0, cz,  3'd0, 0));
        vecs.push_back(mk(0, cz,  1, 0, 0, cz,  3'd0, 0)); // ready while empty ignored
        vecs.push_back(mk(1, ci,  1, 0, 1, ci,  3'd1, 0)); // no same-cycle bypass pop
        vecs.push_back(mk(0, cz,  0, 0, 1, ci,  3'd1, 0));

        // Test 1: reset with enable held high, then release
        reset_reset_n = 1'b0;
        pio_enable    = 1'b1;
        cmd_ready     = 1'b0;
        ovf_clear     = 1'b0;
        drive_cmd(cf);
        tick();
        tick();
        check("reset_state", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));
        reset_reset_n = 1'b1;
        tick();
        check("held_enable_no_push", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));
        tick();
        check("held_enable_still_empty", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));
        pio_enable = 1'b0;
        tick();

        // Test 2: single submit, registered output, hold while not ready
        drive_cmd(ca);
        pio_enable = 1'b1;
        #1;
        check("no_bypass", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));
        tick();
        check("first_push", 64'(obs()), 64'(expv(1, ca, 3'd1, 0)));
        drive_cmd(cg);
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("hold%0d", k), 64'(obs()), 64'(expv(1, ca, 3'd1, 0)));
        end
        pio_enable = 1'b0;
        cmd_ready  = 1'b1;
        tick();
        check("drain_a", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));
        cmd_ready  = 1'b0;

        // Tests 3-5: table
        for (int i = 0; i < vecs.size(); i++) begin
            pio_enable = vecs[i].en;
            drive_cmd(vecs[i].cmd);
            cmd_ready  = vecs[i].rdy;
            ovf_clear  = vecs[i].clr;
            tick();
            check($sformatf("vec%0d", i), 64'(obs()),
                  64'(expv(vecs[i].ev, vecs[i].ecmd, vecs[i].ecnt, vecs[i].eovf)));
        end
        pio_enable = 1'b0;
        cmd_ready  = 1'b0;
        ovf_clear  = 1'b0;

        // Test 6: reset with three queued commands
        submit(cj);
        submit(ck);
        check("three_queued", 64'(obs()), 64'(expv(1, ci, 3'd3, 0)));
        reset_reset_n = 1'b0;
        tick();
        check("reset_mid", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));
        reset_reset_n = 1'b1;
        tick();
        check("post_reset", 64'(obs()), 64'(expv(0, cz, 3'd0, 0)));

`ifdef HPS_CMD_BRIDGE_STATS_EN
        check("stats_reset", 64'({stat_accepted, stat_dropped}), 64'({16'd0, 16'd0}));
        submit(cb);
        submit(cc_);
        submit(cd);
        submit(ce);
        check("stats_four", 64'({stat_accepted, stat_dropped}), 64'({16'd4, 16'd0}));
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        cmd_ready = 1'b1;
        tick();
        tick();
        cmd_ready = 1'b0;
        submit(cf);
        submit(cg);
        submit(ch);
        check("stats_acc_drop", 64'({stat_accepted, stat_dropped}), 64'({16'd2, 16'd1}));
        check("stats_fifo", 64'(obs()), 64'(expv(1, cd, 3'd4, 1)));
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        check("stats_cleared", 64'({stat_accepted, stat_dropped}), 64'({16'd0, 16'd0}));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
